// File: rtl/johnson_pkg.sv
// Shared constants for the Johnson pattern sequencer.
// FSM encoding and shift-direction codes.
package johnson_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  localparam logic       DIR_RIGHT = 1'b0;
  localparam logic       DIR_LEFT  = 1'b1;

endpackage

// File: rtl/johnson_core.sv
// Johnson twisted-ring pattern register with phase index.
// Shifts one position per step; clear forces phase 0.
module johnson_core
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int PH_W  = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             step,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic [PH_W-1:0]  phase
);

  localparam logic [PH_W-1:0] PH_MAX =
    PH_W'(2*WIDTH-1);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q     <= '0;
      phase <= '0;
    end else if (clear) begin
      q     <= '0;
      phase <= '0;
    end else if (step) begin
      if (dir == DIR_LEFT) begin
        q     <= {q[WIDTH-2:0], ~q[WIDTH-1]};
        phase <= (phase == '0) ? PH_MAX
                               : phase - 1'b1;
      end else begin
        q     <= {~q[0], q[WIDTH-1:1]};
        phase <= (phase == PH_MAX) ? '0
                                   : phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run controller: start/stop/clear FSM, prescaler,
// step counter and latched run configuration.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int PRESC_W = 16,
  parameter  int STEP_W  = 8,
  localparam int PH_W    = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               dir,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [STEP_W-1:0]  num_steps,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   q,
  output logic [PH_W-1:0]    phase
);

  logic [0:0]         state;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_l;
  logic [STEP_W-1:0]  cnt;
  logic               dir_l;
  logic               tick;
  logic               step;

  assign busy = (state == ST_RUN);
  assign tick = (presc == presc_l);
  assign step = busy && !stop && !clear && tick;

  // cnt == 0 throughout a run marks continuous mode
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= ST_IDLE;
      presc   <= '0;
      presc_l <= '0;
      cnt     <= '0;
      dir_l   <= DIR_RIGHT;
      done    <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;
      presc <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (start && !stop) begin
            state   <= ST_RUN;
            dir_l   <= dir;
            presc_l <= prescale;
            cnt     <= num_steps;
            presc   <= '0;
          end
        end
        (state == ST_RUN): begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (tick) begin
            presc <= '0;
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
              if (cnt == STEP_W'(1)) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
      endcase
    end
  end

  johnson_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (clear),
    .step  (step),
    .dir   (dir_l),
    .q     (q),
    .phase (phase)
  );

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed scenarios plus
// random commands against a phase-based reference model.
module tb_johnson_seq_ctrl;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] prescale = '0;
  logic [7:0]  num_steps = '0;
  logic        busy;
  logic        done;
  logic [W-1:0] q;
  logic [3:0]  phase;

  int checks = 0;
  int failures = 0;

  // reference model state
  int  m_run = 0;
  int  m_ph = 0;
  int  m_dir = 0;
  int  m_psc = 0;
  int  m_left = 0;
  int  m_cd = 0;
  int  m_done = 0;

  always #5 clk = ~clk;

  johnson_seq_ctrl dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .dir       (dir),
    .prescale  (prescale),
    .num_steps (num_steps),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .phase     (phase)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Johnson pattern as a function of phase index
  function automatic logic [W-1:0] jq(input int p);
    int k;
    if (p <= W)
      return W'(((1 << p) - 1) << (W - p));
    k = p - W;
    return W'((1 << (W - k)) - 1);
  endfunction

  task automatic model_edge();
    m_done = 0;
    if (clear) begin
      m_run = 0;
      m_ph = 0;
    end else if (m_run == 0) begin
      if (start && !stop) begin
        m_run = 1;
        m_dir = int'(dir);
        m_psc = int'(prescale);
        m_left = int'(num_steps);
        m_cd = m_psc + 1;
      end
    end else if (stop) begin
      m_run = 0;
    end else begin
      m_cd--;
      if (m_cd == 0) begin
        m_cd = m_psc + 1;
        m_ph = m_dir ? (m_ph + 2*W - 1) % (2*W)
                     : (m_ph + 1) % (2*W);
        if (m_left != 0) begin
          m_left--;
          if (m_left == 0) begin
            m_run = 0;
            m_done = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(jq(m_ph)));
    chk({tag, ".phase"}, 32'(phase), 32'(m_ph));
    chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // called at a negedge; returns at the next negedge
  task automatic cyc(input string tag,
                     input logic s, input logic sp,
                     input logic cl, input logic d,
                     input logic [15:0] ps,
                     input logic [7:0] ns);
    start = s;
    stop = sp;
    clear = cl;
    dir = d;
    prescale = ps;
    num_steps = ns;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++)
      cyc(tag, 0, 0, 0, 0, 16'd0, 8'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst.q", 32'(q), 32'(0));
    chk("rst.busy", 32'(busy), 32'(0));
    @(negedge clk);
    clr_n = 1'b1;

    idle("idle", 5);

    // counted, right, every cycle
    cyc("cnt3", 1, 0, 0, 0, 16'd0, 8'd3);
    idle("cnt3", 4);
    chk("cnt3.ph_end", 32'(phase), 32'(3));

    // back to phase 0 via clear, then left run
    cyc("clr", 0, 0, 1, 0, 16'd0, 8'd0);
    cyc("left", 1, 0, 0, 1, 16'd2, 8'd2);
    idle("left", 7);
    chk("left.q_end", 32'(q), 32'h03);
    chk("left.ph_end", 32'(phase), 32'(14));

    // continuous wrap then stop
    cyc("clr2", 0, 0, 1, 0, 16'd0, 8'd0);
    cyc("cont", 1, 0, 0, 0, 16'd0, 8'd0);
    idle("cont", 16);
    chk("cont.wrap_q", 32'(q), 32'(0));
    chk("cont.wrap_ph", 32'(phase), 32'(0));
    cyc("stop", 0, 1, 0, 0, 16'd0, 8'd0);
    idle("stop", 3);

    // clear coincident with a scheduled step
    cyc("cs", 1, 0, 0, 0, 16'd1, 8'd5);
    idle("cs", 2);
    cyc("cs.clr", 0, 0, 1, 0, 16'd0, 8'd0);
    idle("cs", 2);

    // start and stop together in idle
    cyc("ss", 1, 1, 0, 0, 16'd0, 8'd4);
    idle("ss", 2);

    // async reset mid-cycle during a run
    cyc("ar", 1, 0, 0, 1, 16'd0, 8'd0);
    idle("ar", 3);
    #2 clr_n = 1'b0;
    #1;
    chk("ar.q", 32'(q), 32'(0));
    chk("ar.phase", 32'(phase), 32'(0));
    chk("ar.busy", 32'(busy), 32'(0));
    chk("ar.done", 32'(done), 32'(0));
    #1 clr_n = 1'b1;
    m_run = 0;
    m_ph = 0;
    m_done = 0;
    @(negedge clk);
    idle("ar.post", 2);

    // randomized command stream
    for (int i = 0; i < 3000; i++) begin
      logic s, sp, cl, d;
      logic [15:0] ps;
      logic [7:0] ns;
      s  = ($urandom_range(0, 9) < 3);
      sp = ($urandom_range(0, 39) == 0);
      cl = ($urandom_range(0, 79) == 0);
      d  = 1'($urandom_range(0, 1));
      ps = 16'($urandom_range(0, 3));
      ns = 8'($urandom_range(0, 6));
      cyc("rnd", s, sp, cl, d, ps, ns);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
